// File: rtl/interrupt_responder.sv
// ============================================================================
//  Module   : interrupt_responder
//  Purpose  : Processor-side interrupt acceptor. Qualifies requests against
//             the global enable and instruction boundaries, saves the return
//             PC into EPC, redirects fetch to the handler, masks nesting
//             until ERET retires, then redirects back to EPC.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module interrupt_responder #(
  parameter int          CNT_W     = 16,
  parameter logic [31:0] RESET_EPC = 32'h0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             interr,
  input  logic [31:0]      interrAddr,
  input  logic [31:0]      PC,
  input  logic             instr_done,
  input  logic             eret,
  input  logic             int_en,
  output logic             pc_sel,
  output logic [31:0]      pc_target,
  output logic [31:0]      epc,
  output logic             in_handler,
  output logic             int_ack,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PENDING  = 3'd1,
    REDIRECT = 3'd2,
    HANDLER  = 3'd3,
    RETURN   = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   load_target;   // capture interrAddr into pc_target
  logic   load_epc;      // capture PC into epc (only on entry to REDIRECT)
  logic   load_return;   // copy epc into pc_target (entry to RETURN)

  // Next-state decode and datapath load strobes
  always_comb begin
    state_nxt   = state;
    load_target = 1'b0;
    load_epc    = 1'b0;
    load_return = 1'b0;
    case (state)
      IDLE: begin
        if (interr && int_en) begin
          load_target = 1'b1;
          if (instr_done) begin
            load_epc  = 1'b1;
            state_nxt = REDIRECT;
          end else begin
            state_nxt = PENDING;
          end
        end
      end
      PENDING: begin
        // A withdrawn request wins over a coincident instruction boundary.
        if (!interr) begin
          state_nxt = IDLE;
        end else if (!int_en) begin
          state_nxt = IDLE;
        end else begin
          load_target = 1'b1;
          if (instr_done) begin
            load_epc  = 1'b1;
            state_nxt = REDIRECT;
          end
        end
      end
      REDIRECT: begin
        state_nxt = HANDLER;
      end
      HANDLER: begin
        // interr and int_en are deliberately ignored here: no nesting.
        if (instr_done && eret) begin
          load_return = 1'b1;
          state_nxt   = RETURN;
        end
      end
      RETURN: begin
        // Requests are only re-evaluated once back in IDLE.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered status strobes, decoded from the state being entered
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_sel     <= 1'b0;
      int_ack    <= 1'b0;
      in_handler <= 1'b0;
    end else begin
      pc_sel     <= (state_nxt == REDIRECT) || (state_nxt == RETURN);
      int_ack    <= (state_nxt == REDIRECT);
      in_handler <= (state_nxt == REDIRECT) || (state_nxt == HANDLER);
    end
  end

  // Redirect target: handler address while requesting, EPC on return
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_target <= 32'h0;
    end else if (load_target) begin
      pc_target <= interrAddr;
    end else if (load_return) begin
      pc_target <= epc;
    end
  end

  // Saved return address, written only when a request is taken
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      epc <= RESET_EPC;
    end else if (load_epc) begin
      epc <= PC;
    end
  end

  // Taken-interrupt counter, wraps naturally at 2^CNT_W
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      taken_count <= '0;
    end else if (state_nxt == REDIRECT) begin
      taken_count <= taken_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_interrupt_responder.sv
// ============================================================================
//  Module   : tb_interrupt_responder
//  Purpose  : Directed self-checking bench for interrupt_responder.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_interrupt_responder;

  logic        clk;
  logic        rst_n;
  logic        interr;
  logic [31:0] interr_addr;
  logic [31:0] pc;
  logic        instr_done;
  logic        eret;
  logic        int_en;
  logic        pc_sel;
  logic [31:0] pc_target;
  logic [31:0] epc;
  logic        in_handler;
  logic        int_ack;
  logic [15:0] taken_count;

  // Narrow-counter instance for the wrap check
  logic        interr4;
  logic        done4;
  logic        eret4;
  logic        pc_sel4;
  logic [31:0] pc_target4;
  logic [31:0] epc4;
  logic        in_handler4;
  logic        int_ack4;
  logic [3:0]  taken_count4;

  int total;
  int bad;

  interrupt_responder #(.CNT_W(16), .RESET_EPC(32'h0)) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .interr     (interr),
    .interrAddr (interr_addr),
    .PC         (pc),
    .instr_done (instr_done),
    .eret       (eret),
    .int_en     (int_en),
    .pc_sel     (pc_sel),
    .pc_target  (pc_target),
    .epc        (epc),
    .in_handler (in_handler),
    .int_ack    (int_ack),
    .taken_count(taken_count)
  );

  interrupt_responder #(.CNT_W(4), .RESET_EPC(32'hDEAD_0000)) dut4 (
    .CLK        (clk),
    .RST_N      (rst_n),
    .interr     (interr4),
    .interrAddr (32'h0000_0090),
    .PC         (32'h0000_0500),
    .instr_done (done4),
    .eret       (eret4),
    .int_en     (1'b1),
    .pc_sel     (pc_sel4),
    .pc_target  (pc_target4),
    .epc        (epc4),
    .in_handler (in_handler4),
    .int_ack    (int_ack4),
    .taken_count(taken_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    interr = 1'b0; interr_addr = 32'h0; pc = 32'h0;
    instr_done = 1'b0; eret = 1'b0; int_en = 1'b0;
    interr4 = 1'b0; done4 = 1'b0; eret4 = 1'b0;
    #12;
    check("rst_pc_sel", {31'b0, pc_sel}, 32'd0);
    check("rst_int_ack", {31'b0, int_ack}, 32'd0);
    check("rst_in_handler", {31'b0, in_handler}, 32'd0);
    check("rst_pc_target", pc_target, 32'h0);
    check("rst_epc", epc, 32'h0);
    check("rst_count", {16'b0, taken_count}, 32'd0);
    check("rst_epc4", epc4, 32'hDEAD_0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Immediate take: interrupt coincides with a retiring instruction
    interr = 1'b1; interr_addr = 32'h40; pc = 32'h100; instr_done = 1'b1; int_en = 1'b1;
    step();
    check("t1_pc_sel", {31'b0, pc_sel}, 32'd1);
    check("t1_int_ack", {31'b0, int_ack}, 32'd1);
    check("t1_pc_target", pc_target, 32'h40);
    check("t1_epc", epc, 32'h100);
    check("t1_count", {16'b0, taken_count}, 32'd1);
    check("t1_in_handler", {31'b0, in_handler}, 32'd1);
    interr = 1'b0; instr_done = 1'b0;
    step();
    check("t1_hnd_pc_sel", {31'b0, pc_sel}, 32'd0);
    check("t1_hnd_int_ack", {31'b0, int_ack}, 32'd0);
    check("t1_hnd_in_handler", {31'b0, in_handler}, 32'd1);

    // Masked request inside the handler, then ERET and retake via IDLE
    interr = 1'b1; interr_addr = 32'h80; instr_done = 1'b1;
    step();
    check("t4_masked_pc_sel", {31'b0, pc_sel}, 32'd0);
    check("t4_masked_count", {16'b0, taken_count}, 32'd1);
    check("t4_masked_epc", epc, 32'h100);
    eret = 1'b1; instr_done = 1'b1;
    step();
    check("t4_ret_pc_sel", {31'b0, pc_sel}, 32'd1);
    check("t4_ret_pc_target", pc_target, 32'h100);
    check("t4_ret_in_handler", {31'b0, in_handler}, 32'd0);
    check("t4_ret_int_ack", {31'b0, int_ack}, 32'd0);
    eret = 1'b0; pc = 32'h300;
    step();
    check("t4_idle_pc_sel", {31'b0, pc_sel}, 32'd0);
    check("t4_idle_in_handler", {31'b0, in_handler}, 32'd0);
    step();
    check("t4_retake_pc_sel", {31'b0, pc_sel}, 32'd1);
    check("t4_retake_int_ack", {31'b0, int_ack}, 32'd1);
    check("t4_retake_pc_target", pc_target, 32'h80);
    check("t4_retake_epc", epc, 32'h300);
    check("t4_retake_count", {16'b0, taken_count}, 32'd2);
    interr = 1'b0; instr_done = 1'b0;
    step();
    eret = 1'b1; instr_done = 1'b1;
    step();
    check("t4b_ret_pc_target", pc_target, 32'h300);
    eret = 1'b0; instr_done = 1'b0;
    step();
    check("t4b_idle_pc_sel", {31'b0, pc_sel}, 32'd0);

    // Pending request with a moving target address
    interr = 1'b1; interr_addr = 32'h40; instr_done = 1'b0;
    step();
    check("t2_pend_pc_sel", {31'b0, pc_sel}, 32'd0);
    check("t2_pend_target0", pc_target, 32'h40);
    interr_addr = 32'h42;
    step();
    check("t2_pend_target1", pc_target, 32'h42);
    interr_addr = 32'h44;
    step();
    check("t2_pend_target2", pc_target, 32'h44);
    check("t2_pend_in_handler", {31'b0, in_handler}, 32'd0);
    instr_done = 1'b1; pc = 32'h208;
    step();
    check("t2_take_pc_sel", {31'b0, pc_sel}, 32'd1);
    check("t2_take_pc_target", pc_target, 32'h44);
    check("t2_take_epc", epc, 32'h208);
    check("t2_take_count", {16'b0, taken_count}, 32'd3);
    interr = 1'b0; instr_done = 1'b0;
    step();
    eret = 1'b1; instr_done = 1'b1;
    step();
    eret = 1'b0; instr_done = 1'b0;
    step();

    // Withdrawn request: withdrawal beats a coincident boundary
    interr = 1'b1; interr_addr = 32'h50; instr_done = 1'b0;
    step();
    check("t3_pend_pc_sel", {31'b0, pc_sel}, 32'd0);
    interr = 1'b0; instr_done = 1'b1;
    step();
    check("t3_wd_pc_sel", {31'b0, pc_sel}, 32'd0);
    step();
    check("t3_wd2_pc_sel", {31'b0, pc_sel}, 32'd0);
    check("t3_wd_count", {16'b0, taken_count}, 32'd3);
    check("t3_wd_in_handler", {31'b0, in_handler}, 32'd0);
    check("t3_wd_epc", epc, 32'h208);

    // Globally disabled: no take; stray ERETs in IDLE do nothing
    int_en = 1'b0; interr = 1'b1; instr_done = 1'b1; pc = 32'h600;
    for (int i = 0; i < 5; i++) begin
      eret = i[0];
      step();
      check("t5_dis_pc_sel", {31'b0, pc_sel}, 32'd0);
      check("t5_dis_in_handler", {31'b0, in_handler}, 32'd0);
    end
    check("t5_dis_count", {16'b0, taken_count}, 32'd3);
    check("t5_dis_epc", epc, 32'h208);
    check("t5_dis_pc_target", pc_target, 32'h50);
    eret = 1'b0;

    // Asynchronous reset in the middle of a handler
    int_en = 1'b1; interr = 1'b1; interr_addr = 32'h60; pc = 32'h400; instr_done = 1'b1;
    step();
    check("t6_take_pc_sel", {31'b0, pc_sel}, 32'd1);
    interr = 1'b0; instr_done = 1'b0;
    step();
    check("t6_hnd_in_handler", {31'b0, in_handler}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_arst_in_handler", {31'b0, in_handler}, 32'd0);
    check("t6_arst_pc_sel", {31'b0, pc_sel}, 32'd0);
    check("t6_arst_epc", epc, 32'h0);
    check("t6_arst_count", {16'b0, taken_count}, 32'd0);
    check("t6_arst_pc_target", pc_target, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("t6_post_pc_sel", {31'b0, pc_sel}, 32'd0);
    check("t6_post_in_handler", {31'b0, in_handler}, 32'd0);

    // Narrow counter: 16 takes wrap a 4-bit count back to zero
    for (int i = 0; i < 16; i++) begin
      logic [3:0] want;
      want = 4'(i + 1);
      interr4 = 1'b1; done4 = 1'b1; eret4 = 1'b0;
      step();
      check("t6w_pc_sel", {31'b0, pc_sel4}, 32'd1);
      check("t6w_count", {28'b0, taken_count4}, {28'b0, want});
      interr4 = 1'b0; done4 = 1'b0;
      step();
      eret4 = 1'b1; done4 = 1'b1;
      step();
      eret4 = 1'b0; done4 = 1'b0;
      step();
    end
    check("t6w_final_count", {28'b0, taken_count4}, 32'd0);
    check("t6w_epc4", epc4, 32'h500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
